// File: rtl/reg_dump_if.sv
// Register-file read port plus the outbound byte stream of the dump engine.
// master = dump engine, slave = register file / stream sink side.
interface reg_dump_if;
   logic [3:0] rd_sel;
   logic [7:0] rd_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output rd_sel,
      output out_data,
      output out_valid,
      input  rd_data,
      input  out_ready
   );

   modport slave (
      input  rd_sel,
      input  out_data,
      input  out_valid,
      output rd_data,
      output out_ready
   );
endinterface

// File: rtl/reg_dump_tx.sv
// Register-file dump engine: walks the read select from 0 to NUM_REGS-1 and
// emits one packet (header, data bytes, 8-bit wrapping checksum of the data)
// on a valid/ready byte stream. All outputs come straight from flops.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// HDR   | presenting the header byte
// FETCH | sampling rd_data for rd_sel = index, accumulating checksum
// SEND  | presenting the captured data byte
// CSUM  | presenting the checksum byte
// DONE  | one-cycle done pulse, back to IDLE
module reg_dump_tx #(
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] HEADER   = 8'hA5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   reg_dump_if.master   bus,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_FETCH,
      S_SEND,
      S_CSUM,
      S_DONE
   } state_t;

   // Terminal index; the index never wraps because it stops here.
   localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

   state_t     state, state_nx;
   logic [3:0] index, index_nx;
   logic [7:0] checksum, csum_nx;
   logic [7:0] data_q, data_nx;
   logic       valid_q;

   assign bus.rd_sel    = index;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;

   // State, datapath and registered outputs; outputs decode the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         index    <= 4'd0;
         checksum <= 8'd0;
         data_q   <= 8'd0;
         valid_q  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         index    <= index_nx;
         checksum <= csum_nx;
         data_q   <= data_nx;
         valid_q  <= (state_nx == S_HDR) || (state_nx == S_SEND) || (state_nx == S_CSUM);
         busy     <= (state_nx == S_HDR) || (state_nx == S_FETCH) ||
                     (state_nx == S_SEND) || (state_nx == S_CSUM);
         done     <= (state_nx == S_DONE);
      end
   end

   // Next-state and datapath updates; a byte only advances on a transfer, so
   // out_data/out_valid hold while the sink stalls.
   always_comb begin
      state_nx = state;
      index_nx = index;
      csum_nx  = checksum;
      data_nx  = data_q;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               index_nx = 4'd0;
               csum_nx  = 8'd0;
               data_nx  = HEADER;
               state_nx = S_HDR;
            end
         end
         S_HDR: begin
            if (bus.out_ready) state_nx = S_FETCH;
         end
         S_FETCH: begin
            data_nx  = bus.rd_data;
            csum_nx  = checksum + bus.rd_data;
            state_nx = S_SEND;
         end
         S_SEND: begin
            if (bus.out_ready) begin
               if (index == LAST) begin
                  data_nx  = checksum;
                  state_nx = S_CSUM;
               end else begin
                  index_nx = index + 4'd1;
                  state_nx = S_FETCH;
               end
            end
         end
         S_CSUM: begin
            if (bus.out_ready) state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: register file model, stream capture and
// hand-computed packets.
module tb_reg_dump_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done;

   reg_dump_if bus ();

   logic [7:0] regs [16];
   logic [7:0] exp_d [16];
   logic [7:0] got_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt;
   int done_cyc;
   bit aborted;

   assign bus.rd_data = regs[bus.rd_sel];

   reg_dump_tx #(.NUM_REGS(16), .HEADER(8'hA5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One dump with optional disturbances; bytes transferred land in got_q.
   task automatic run_pkt(input bit rnd, input bit stall_en, input bit restart,
                          input bit rst_r9, input bit wr_r4);
      int  stall = 0;
      bit  hdr_done = 0, r7_done = 0, rs_done = 0, wr_done = 0;
      bit  prev_stall = 0;
      logic [7:0] prev_data = 8'd0;
      bit  finished = 0;
      got_q.delete();
      done_cnt = 0;
      done_cyc = -1;
      aborted  = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (stall_en && !hdr_done && bus.out_valid && busy && bus.out_data == 8'hA5) begin
            stall = 5; hdr_done = 1;
         end
         if (stall_en && !r7_done && bus.out_valid && busy && bus.rd_sel == 4'd7) begin
            stall = 5; r7_done = 1;
         end
         if (stall > 0) begin
            bus.out_ready = 1'b0;
            stall--;
         end else begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (restart && !rs_done && bus.out_valid && bus.rd_sel == 4'd3) begin
            start = 1'b1; rs_done = 1;
         end
         if (wr_r4 && !wr_done && busy && bus.rd_sel == 4'd4) begin
            regs[12] = 8'h55; regs[2] = 8'h99; wr_done = 1;
         end
         if (rst_r9 && bus.out_valid && bus.rd_sel == 4'd9) begin
            rst = 1'b1; aborted = 1;
         end
         @(negedge clk);
         if (prev_stall) begin
            check_val("hold_valid", 32'(bus.out_valid), 32'd1);
            check_val("hold_data", 32'(bus.out_data), 32'(prev_data));
         end
         if (aborted) begin
            check_val("abort_valid", 32'(bus.out_valid), 32'd0);
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_sel", 32'(bus.rd_sel), 32'd0);
            finished = 1;
            break;
         end
         if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         if (done_cyc >= 0 && k >= done_cyc + 4) begin
            finished = 1;
            break;
         end
      end
      check_val("finished", 32'(finished), 32'd1);
      if (aborted) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("abort_hold_valid", 32'(bus.out_valid), 32'd0);
         rst = 1'b0;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
   endtask

   task automatic compare_pkt(input string tag, input logic [7:0] csum);
      check_val({tag, "_len"}, 32'(got_q.size()), 32'd18);
      if (got_q.size() == 18) begin
         check_val({tag, "_hdr"}, 32'(got_q[0]), 32'hA5);
         for (int i = 0; i < 16; i++)
            check_val($sformatf("%s_d%0d", tag, i), 32'(got_q[i+1]), 32'(exp_d[i]));
         check_val({tag, "_csum"}, 32'(got_q[17]), 32'(csum));
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) regs[i] = 8'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_sel", 32'(bus.rd_sel), 32'd0);
      check_val("rst_data", 32'(bus.out_data), 32'd0);
      check_val("rst_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      #1 rst = 1'b0;

      // Incrementing pattern, sink always ready.
      for (int i = 0; i < 16; i++) begin regs[i] = 8'(i); exp_d[i] = 8'(i); end
      run_pkt(0, 0, 0, 0, 0);
      compare_pkt("inc", 8'h78);
      check_val("inc_done_cnt", 32'(done_cnt), 32'd1);
      check_val("inc_latency", 32'(done_cyc), 32'd35);
      check_val("inc_busy_after", 32'(busy), 32'd0);

      // All ones: checksum wraps.
      for (int i = 0; i < 16; i++) begin regs[i] = 8'hFF; exp_d[i] = 8'hFF; end
      run_pkt(0, 0, 0, 0, 0);
      compare_pkt("ff", 8'hF0);
      check_val("ff_done_cnt", 32'(done_cnt), 32'd1);

      // Random backpressure plus long stalls on the header and r7.
      for (int i = 0; i < 16; i++) begin regs[i] = 8'(i); exp_d[i] = 8'(i); end
      run_pkt(1, 1, 0, 0, 0);
      compare_pkt("bp", 8'h78);
      check_val("bp_done_cnt", 32'(done_cnt), 32'd1);

      // Second start during SEND of r3 is dropped.
      run_pkt(0, 0, 1, 0, 0);
      compare_pkt("restart", 8'h78);
      check_val("restart_done_cnt", 32'(done_cnt), 32'd1);
      check_val("restart_busy", 32'(busy), 32'd0);

      // Reset during SEND of r9, then a clean packet.
      run_pkt(0, 0, 0, 1, 0);
      check_val("abort_len", 32'(got_q.size()), 32'd10);
      check_val("abort_done_cnt", 32'(done_cnt), 32'd0);
      run_pkt(0, 0, 0, 0, 0);
      compare_pkt("post_abort", 8'h78);
      check_val("post_abort_done_cnt", 32'(done_cnt), 32'd1);

      // Writes while the dump is at r4: r12 changes, r2 already sampled.
      for (int i = 0; i < 16; i++) begin regs[i] = 8'(i); exp_d[i] = 8'(i); end
      exp_d[12] = 8'h55;
      run_pkt(0, 0, 0, 0, 1);
      compare_pkt("wr", 8'hC1);
      check_val("wr_done_cnt", 32'(done_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
